// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : regfile_pkg
//  Description : Shared constants, types and address-decode helper for the
//                multi-port GPR + HILO register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 6'd0;
  localparam logic [ADDR_W-1:0] REG_HILO = 6'd32;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [2*DATA_W-1:0] reg_data_t;

  // Address holds real storage: GPR 1..31 or HILO at 32. Zero reg and 33..63 do not.
  function automatic logic is_mapped(input reg_addr_t addr);
    return (addr != REG_ZERO) && (addr <= REG_HILO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_sel
//  Description : Write-port selector. Reports whether any enabled write port
//                targets the query address and returns the data of the
//                highest-index matching port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_sel #(
  parameter int NWR    = 4,
  parameter int ADDR_W = 6,
  parameter int DW     = 64
) (
  input  logic [NWR-1:0]        we_i,
  input  logic [NWR*ADDR_W-1:0] waddr_i,
  input  logic [NWR*DW-1:0]     wdata_i,
  input  logic [ADDR_W-1:0]     qaddr_i,
  output logic                  hit_o,
  output logic [DW-1:0]         data_o
);

  // Scan ports low to high so a later (higher-priority) match overrides earlier ones
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we_i[p] && (waddr_i[p*ADDR_W +: ADDR_W] == qaddr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[p*DW +: DW];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port GPR (1..31) + 64-bit HILO (32) register file with
//                a per-register busy scoreboard. NRD combinational read ports,
//                NWR write ports (higher index wins on same-address writes).
//                Optional macro REGFILE_BYPASS_EN forwards same-cycle write
//                data to the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NRD    = 16,
  parameter int NWR    = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NRD*ADDR_W-1:0]   raddr_i,
  output logic [NRD*2*DATA_W-1:0] rdata_o,
  output logic [NRD-1:0]          rbusy_o,
  input  logic [NWR-1:0]          we_i,
  input  logic [NWR*ADDR_W-1:0]   waddr_i,
  input  logic [NWR*2*DATA_W-1:0] wdata_i,
  input  logic                    alloc_valid_i,
  input  logic [ADDR_W-1:0]       alloc_addr_i,
  input  logic                    flush_i
);

  localparam int NREG     = 1 << ADDR_W;
  localparam int HILO_IDX = int'(REG_HILO);
  localparam int RW       = 2 * DATA_W;

  // Flat read view of every address; unmapped entries are tied to zero
  logic [RW-1:0]       w_rf_view [NREG];
  logic [NREG-1:0]     w_busy_view;
  logic [HILO_IDX:1]   w_wr_hit;
  logic [HILO_IDX:1]   busy_q;
  logic [HILO_IDX:1]   busy_d;
  logic [NWR*DATA_W-1:0] w_wdata_lo;

  // GPR storage only needs the low half of each write port
  for (genvar p = 0; p < NWR; p++) begin : g_wlo
    assign w_wdata_lo[p*DATA_W +: DATA_W] = wdata_i[p*RW +: DATA_W];
  end

  assign w_rf_view[0] = '0;

  for (genvar a = HILO_IDX + 1; a < NREG; a++) begin : g_unmapped
    assign w_rf_view[a] = '0;
  end

  // One write selector and one storage register per mapped address
  for (genvar r = 1; r <= HILO_IDX; r++) begin : g_reg
    localparam logic [ADDR_W-1:0] c_addr = ADDR_W'(r);

    if (r == HILO_IDX) begin : g_hilo
      logic [RW-1:0] hilo_q;
      logic          w_hit;
      logic [RW-1:0] w_data;

      regfile_wr_sel #(
        .NWR    (NWR),
        .ADDR_W (ADDR_W),
        .DW     (RW)
      ) u_wr_sel (
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .qaddr_i (c_addr),
        .hit_o   (w_hit),
        .data_o  (w_data)
      );

      // Commit the winning 64-bit write into HILO
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          hilo_q <= '0;
        end else if (w_hit) begin
          hilo_q <= w_data;
        end
      end

      assign w_wr_hit[r]  = w_hit;
      assign w_rf_view[r] = hilo_q;
    end else begin : g_gpr
      logic [DATA_W-1:0] gpr_q;
      logic              w_hit;
      logic [DATA_W-1:0] w_data;

      regfile_wr_sel #(
        .NWR    (NWR),
        .ADDR_W (ADDR_W),
        .DW     (DATA_W)
      ) u_wr_sel (
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (w_wdata_lo),
        .qaddr_i (c_addr),
        .hit_o   (w_hit),
        .data_o  (w_data)
      );

      // Commit the winning write's low half into this GPR
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          gpr_q <= '0;
        end else if (w_hit) begin
          gpr_q <= w_data;
        end
      end

      assign w_wr_hit[r]  = w_hit;
      assign w_rf_view[r] = {{DATA_W{1'b0}}, gpr_q};
    end
  end

  // Scoreboard next state: writeback clears, allocate sets (and beats a same-cycle clear), flush clears all
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r <= HILO_IDX; r++) begin
      if (w_wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end else if (alloc_valid_i) begin
      for (int r = 1; r <= HILO_IDX; r++) begin
        if (alloc_addr_i == ADDR_W'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign w_busy_view = {{(NREG - HILO_IDX - 1){1'b0}}, busy_q, 1'b0};

  // Read ports
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_raddr;
    logic [RW-1:0]     w_reg_data;
    logic              w_reg_busy;

    assign w_raddr    = raddr_i[i*ADDR_W +: ADDR_W];
    assign w_reg_data = w_rf_view[w_raddr];
    assign w_reg_busy = w_busy_view[w_raddr];

`ifdef REGFILE_BYPASS_EN
    logic          w_byp_hit;
    logic [RW-1:0] w_byp_raw;
    logic [RW-1:0] w_byp_data;
    logic          w_byp_use;
    logic          w_alloc_same;

    regfile_wr_sel #(
      .NWR    (NWR),
      .ADDR_W (ADDR_W),
      .DW     (RW)
    ) u_byp_sel (
      .we_i    (we_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .qaddr_i (w_raddr),
      .hit_o   (w_byp_hit),
      .data_o  (w_byp_raw)
    );

    // Forwarded GPR data is truncated exactly as storage would truncate it
    assign w_byp_data   = (w_raddr == REG_HILO) ? w_byp_raw
                                                : {{DATA_W{1'b0}}, w_byp_raw[DATA_W-1:0]};
    assign w_byp_use    = w_byp_hit && is_mapped(w_raddr);
    assign w_alloc_same = alloc_valid_i && (alloc_addr_i == w_raddr);

    assign rdata_o[i*RW +: RW] = w_byp_use ? w_byp_data   : w_reg_data;
    assign rbusy_o[i]          = w_byp_use ? w_alloc_same : w_reg_busy;
`else
    assign rdata_o[i*RW +: RW] = w_reg_data;
    assign rbusy_o[i]          = w_reg_busy;
`endif
  end

endmodule
`default_nettype wire
